// File: rtl/index_xfer_ctrl.sv
// Register-file transfer sequencer for implied-mode 6502 ops (TAX..DEY).
// One op per handshake: IDLE -> SRC -> DST -> FIN, or IDLE -> FIN when the opcode is unsupported.
module index_xfer_ctrl (
   input  logic       CLK,
   input  logic       RST,
   input  logic       OP_VALID,
   input  logic [7:0] OP_CODE,
   output logic       OP_READY,
   input  logic [7:0] BUS,
   output logic       A_BE,
   output logic       X_BE,
   output logic       Y_BE,
   output logic       S_BE,
   output logic       A_LOAD,
   output logic       X_LOAD,
   output logic       Y_LOAD,
   output logic       S_LOAD,
   output logic       INC_EN,
   output logic       DEC_EN,
   output logic       FLAG_WE,
   output logic       FLAG_N,
   output logic       FLAG_Z,
   output logic       DONE,
   output logic       ILLEGAL
);

   typedef enum logic [1:0] {IDLE, SRC, DST, FIN} state_t;

   localparam logic [3:0] R_A = 4'b0001;
   localparam logic [3:0] R_X = 4'b0010;
   localparam logic [3:0] R_Y = 4'b0100;
   localparam logic [3:0] R_S = 4'b1000;

   state_t     state_q;
   logic [3:0] dst_q, be_q, load_q;
   logic       fwe_q, ready_q, inc_en_q, dec_en_q, flag_we_q, done_q, illegal_q;

   logic [3:0] src_d, dst_d;
   logic       inc_d, dec_d, fwe_d, legal_d;

   always_comb begin
      src_d   = '0;
      dst_d   = '0;
      inc_d   = 1'b0;
      dec_d   = 1'b0;
      fwe_d   = 1'b1;
      legal_d = 1'b1;
      case (OP_CODE)
         8'hAA: begin src_d = R_A; dst_d = R_X; end
         8'h8A: begin src_d = R_X; dst_d = R_A; end
         8'hA8: begin src_d = R_A; dst_d = R_Y; end
         8'h98: begin src_d = R_Y; dst_d = R_A; end
         8'hBA: begin src_d = R_S; dst_d = R_X; end
         8'h9A: begin src_d = R_X; dst_d = R_S; fwe_d = 1'b0; end
         8'hE8: begin src_d = R_X; dst_d = R_X; inc_d = 1'b1; end
         8'hCA: begin src_d = R_X; dst_d = R_X; dec_d = 1'b1; end
         8'hC8: begin src_d = R_Y; dst_d = R_Y; inc_d = 1'b1; end
         8'h88: begin src_d = R_Y; dst_d = R_Y; dec_d = 1'b1; end
         default: begin legal_d = 1'b0; fwe_d = 1'b0; end
      endcase
   end

   // Strobes are registered one state ahead, so each output reflects the state being entered.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         dst_q     <= '0;
         fwe_q     <= 1'b0;
         ready_q   <= 1'b1;
         be_q      <= '0;
         load_q    <= '0;
         inc_en_q  <= 1'b0;
         dec_en_q  <= 1'b0;
         flag_we_q <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (OP_VALID) begin
                  dst_q   <= dst_d;
                  fwe_q   <= fwe_d;
                  ready_q <= 1'b0;
                  if (legal_d) begin
                     state_q  <= SRC;
                     be_q     <= src_d;
                     inc_en_q <= inc_d;
                     dec_en_q <= dec_d;
                  end else begin
                     state_q   <= FIN;
                     done_q    <= 1'b1;
                     illegal_q <= 1'b1;
                  end
               end
            end
            SRC: begin
               state_q   <= DST;
               load_q    <= dst_q;
               flag_we_q <= fwe_q;
            end
            DST: begin
               state_q   <= FIN;
               be_q      <= '0;
               load_q    <= '0;
               inc_en_q  <= 1'b0;
               dec_en_q  <= 1'b0;
               flag_we_q <= 1'b0;
               done_q    <= 1'b1;
            end
            FIN: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   logic in_dst;
   assign in_dst = (state_q == DST);

   assign OP_READY = ready_q;
   assign A_BE     = be_q[0];
   assign X_BE     = be_q[1];
   assign Y_BE     = be_q[2];
   assign S_BE     = be_q[3];
   assign A_LOAD   = load_q[0];
   assign X_LOAD   = load_q[1];
   assign Y_LOAD   = load_q[2];
   assign S_LOAD   = load_q[3];
   assign INC_EN   = inc_en_q;
   assign DEC_EN   = dec_en_q;
   assign FLAG_WE  = flag_we_q;
   assign FLAG_N   = in_dst & BUS[7];
   assign FLAG_Z   = in_dst & (BUS == 8'h00);
   assign DONE     = done_q;
   assign ILLEGAL  = illegal_q;

endmodule

// File: tb/tb_index_xfer_ctrl.sv
// Bench for index_xfer_ctrl: models the register file, adjuster and per-op cycle timeline.
module tb_index_xfer_ctrl;

   logic       CLK = 1'b0;
   logic       RST;
   logic       OP_VALID;
   logic [7:0] OP_CODE;
   logic       OP_READY;
   logic [7:0] BUS;
   logic       A_BE, X_BE, Y_BE, S_BE;
   logic       A_LOAD, X_LOAD, Y_LOAD, S_LOAD;
   logic       INC_EN, DEC_EN, FLAG_WE, FLAG_N, FLAG_Z, DONE, ILLEGAL;

   index_xfer_ctrl dut (
      .CLK(CLK), .RST(RST), .OP_VALID(OP_VALID), .OP_CODE(OP_CODE), .OP_READY(OP_READY),
      .BUS(BUS),
      .A_BE(A_BE), .X_BE(X_BE), .Y_BE(Y_BE), .S_BE(S_BE),
      .A_LOAD(A_LOAD), .X_LOAD(X_LOAD), .Y_LOAD(Y_LOAD), .S_LOAD(S_LOAD),
      .INC_EN(INC_EN), .DEC_EN(DEC_EN), .FLAG_WE(FLAG_WE), .FLAG_N(FLAG_N),
      .FLAG_Z(FLAG_Z), .DONE(DONE), .ILLEGAL(ILLEGAL)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;
   int yl_cnt   = 0;

   // Reference model: register values (A,X,Y,S = 0..3) and the op in flight.
   logic [7:0] regs [4];
   bit         busy = 0;
   int         cyc  = 0;
   bit         m_ok, m_fl;
   int         m_src, m_dst, m_adj;

   logic [7:0] legal_ops [10] = '{8'hAA, 8'h8A, 8'hA8, 8'h98, 8'hBA,
                                  8'h9A, 8'hE8, 8'hCA, 8'hC8, 8'h88};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void decode(input logic [7:0] op);
      m_ok = 1; m_adj = 0; m_fl = 1; m_src = 0; m_dst = 0;
      case (op)
         8'hAA: begin m_src = 0; m_dst = 1; end
         8'h8A: begin m_src = 1; m_dst = 0; end
         8'hA8: begin m_src = 0; m_dst = 2; end
         8'h98: begin m_src = 2; m_dst = 0; end
         8'hBA: begin m_src = 3; m_dst = 1; end
         8'h9A: begin m_src = 1; m_dst = 3; m_fl = 0; end
         8'hE8: begin m_src = 1; m_dst = 1; m_adj = 1; end
         8'hCA: begin m_src = 1; m_dst = 1; m_adj = -1; end
         8'hC8: begin m_src = 2; m_dst = 2; m_adj = 1; end
         8'h88: begin m_src = 2; m_dst = 2; m_adj = -1; end
         default: begin m_ok = 0; m_fl = 0; end
      endcase
   endfunction

   // Legal ops take 3 busy cycles (src, dst, done); illegal ones report done immediately.
   function automatic int op_len();
      return m_ok ? 3 : 1;
   endfunction

   function automatic void model_edge(input logic v, input logic [7:0] op);
      if (busy) begin
         if (m_ok && cyc == 2) regs[m_dst] = BUS;
         cyc++;
         if (cyc > op_len()) busy = 0;
      end else if (v) begin
         busy = 1;
         cyc  = 1;
         decode(op);
      end
   endfunction

   function automatic logic [7:0] adjuster_out();
      logic [7:0] v;
      if (busy && m_ok && (cyc == 1 || cyc == 2)) begin
         v = regs[m_src];
         if (m_adj > 0) v = v + 8'd1;
         else if (m_adj < 0) v = v - 8'd1;
         return v;
      end
      return 8'($urandom);
   endfunction

   function automatic logic [15:0] exp_vec();
      logic [3:0] be = '0;
      logic [3:0] ld = '0;
      logic inc = 0, dec = 0, fwe = 0, n = 0, z = 0, done = 0, ill = 0;
      if (busy && m_ok) begin
         if (cyc <= 2) begin
            be  = 4'(1 << m_src);
            inc = (m_adj > 0);
            dec = (m_adj < 0);
         end
         if (cyc == 2) begin
            ld  = 4'(1 << m_dst);
            fwe = m_fl;
            n   = BUS[7];
            z   = (BUS == 8'h00);
         end
         if (cyc == 3) done = 1;
      end else if (busy) begin
         done = 1;
         ill  = 1;
      end
      return {!busy, be, ld, inc, dec, fwe, n, z, done, ill};
   endfunction

   function automatic logic [15:0] obs_vec();
      return {OP_READY, S_BE, Y_BE, X_BE, A_BE, S_LOAD, Y_LOAD, X_LOAD, A_LOAD,
              INC_EN, DEC_EN, FLAG_WE, FLAG_N, FLAG_Z, DONE, ILLEGAL};
   endfunction

   task automatic step(input logic v, input logic [7:0] op);
      OP_VALID = v;
      OP_CODE  = op;
      @(posedge CLK);
      model_edge(v, op);
      #1 BUS = adjuster_out();
      #1;
      chk("outputs", 32'(obs_vec()), 32'(exp_vec()));
      chk("be_onehot0", 32'($onehot0({A_BE, X_BE, Y_BE, S_BE})), 32'd1);
      chk("load_onehot0", 32'($onehot0({A_LOAD, X_LOAD, Y_LOAD, S_LOAD})), 32'd1);
      chk("inc_dec_excl", 32'(INC_EN & DEC_EN), 32'd0);
      if (Y_LOAD) yl_cnt++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
   endtask

   initial begin
      for (int i = 0; i < 4; i++) regs[i] = 8'($urandom);
      RST = 1'b1; OP_VALID = 1'b0; OP_CODE = 8'h00; BUS = 8'h5A;
      #12;
      chk("reset_vec", 32'(obs_vec()), 32'h8000);
      RST = 1'b0;
      idle(2);

      // TAX with A=80: negative result
      regs[0] = 8'h80;
      step(1'b1, 8'hAA);
      idle(4);
      chk("tax_x", 32'(regs[1]), 32'h80);

      // INX wrapping FF -> 00
      regs[1] = 8'hFF;
      step(1'b1, 8'hE8);
      idle(4);

      // TXS with X=00: no flag write
      regs[1] = 8'h00;
      step(1'b1, 8'h9A);
      idle(4);

      // DEY wrapping 00 -> FF
      regs[2] = 8'h00;
      step(1'b1, 8'h88);
      idle(4);

      // unsupported NOP
      step(1'b1, 8'hEA);
      idle(3);

      // back-to-back TAY then DEY with valid held high
      yl_cnt = 0;
      regs[0] = 8'h42;
      step(1'b1, 8'hA8);
      for (int i = 0; i < 4; i++) step(1'b1, 8'h88);
      idle(5);
      chk("yload_count", 32'(yl_cnt), 32'd2);
      chk("tay_dey_y", 32'(regs[2]), 32'h41);

      // reset asserted in the middle of DST
      regs[0] = 8'h11;
      step(1'b1, 8'hAA);
      step(1'b0, 8'h00);
      chk("pre_rst_xload", 32'(X_LOAD), 32'd1);
      #1 RST = 1'b1;
      #1;
      chk("rst_xload", 32'(X_LOAD), 32'd0);
      chk("rst_vec", 32'(obs_vec()), 32'h8000);
      busy = 0; cyc = 0;
      @(posedge CLK);
      #2 RST = 1'b0;
      idle(2);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [7:0] op;
         logic [31:0] sel;
         sel = $urandom_range(0, 9);
         op  = (sel < 8) ? legal_ops[$urandom_range(0, 9)] : 8'($urandom);
         step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, op);
      end
      idle(5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/index_xfer_ctrl.md
Name: index_xfer_ctrl

Overview:
- Control sequencer for the 6502 register file (A, X, Y, S on a shared 8-bit internal bus).
- Accepts one implied-mode transfer or index inc/dec opcode per valid/ready handshake.
- Drives the per-register bus-enable (_BE) and load (_LOAD) strobes, plus INC_EN/DEC_EN to the bus adjuster.
- Computes N/Z flag updates from the bus value written back.

Parameters:
- None.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- OP_VALID  in  1  opcode offered.
- OP_CODE  in  8  6502 opcode byte.
- OP_READY  out  1  controller can accept an opcode.
- BUS  in  8  internal data bus as seen after the adjuster.
- A_BE, X_BE, Y_BE, S_BE  out  1 each  source register drives bus.
- A_LOAD, X_LOAD, Y_LOAD, S_LOAD  out  1 each  destination register captures bus.
- INC_EN  out  1  adjuster adds 1 to bus.
- DEC_EN  out  1  adjuster subtracts 1 from bus.
- FLAG_WE  out  1  status register captures FLAG_N/FLAG_Z.
- FLAG_N  out  1  equals BUS[7].
- FLAG_Z  out  1  equals (BUS == 8'h00).
- DONE  out  1  one-cycle completion pulse.
- ILLEGAL  out  1  qualifies DONE: opcode not supported.

Behaviour:
- Clock/reset: one clock domain. RST is asynchronous and active-high; it forces state to IDLE and clears the opcode register.
- Reset values: OP_READY=1; every other output 0 (FLAG_N/FLAG_Z gated to 0 outside DST).
- Decode table (opcode: source -> destination, adjust, flags):
  - AA TAX: A->X, flags.
  - 8A TXA: X->A, flags.
  - A8 TAY: A->Y, flags.
  - 98 TYA: Y->A, flags.
  - BA TSX: S->X, flags.
  - 9A TXS: X->S, no flags.
  - E8 INX: X->X +1, flags.
  - CA DEX: X->X -1, flags.
  - C8 INY: Y->Y +1, flags.
  - 88 DEY: Y->Y -1, flags.
  - Any other value is illegal.
- States: IDLE, SRC, DST, FIN. All strobes are Moore outputs decoded from state plus the latched opcode, so they are glitch-free.
- IDLE:
  - OP_READY=1.
  - On a rising edge with OP_VALID=1, OP_CODE is latched.
  - Legal opcode -> SRC. Illegal opcode -> FIN with the illegal marker set.
  - OP_CODE is ignored while OP_READY=0.
- SRC (1 cycle):
  - Source _BE=1.
  - INC_EN or DEC_EN =1 for inc/dec opcodes.
  - -> DST.
- DST (1 cycle):
  - Source _BE and INC_EN/DEC_EN stay asserted; destination _LOAD=1.
  - FLAG_WE=1 except TXS.
  - FLAG_N/FLAG_Z are combinational from BUS during DST only.
  - -> FIN.
- FIN (1 cycle):
  - DONE=1; ILLEGAL=1 if opcode was illegal.
  - All strobes 0. -> IDLE.
- Latency:
  - Legal op: accept edge -> SRC, DST, FIN -> ready again 4 cycles after accept.
  - Illegal op: FIN immediately after accept; ready again 2 cycles after accept.
- Invariants:
  - At most one _BE high in any cycle.
  - At most one _LOAD high in any cycle.
  - INC_EN and DEC_EN are never both high.
  - _LOAD is never high outside DST.
  - For INX/DEX/INY/DEY the source and destination are the same register: _BE and _LOAD of that register are both high in DST.
- Wrap-around: arithmetic is done by the adjuster. FF+1 on BUS reads 00 -> FLAG_Z=1, FLAG_N=0. 00-1 reads FF -> FLAG_N=1.
- Reset mid-operation: all strobes drop asynchronously with RST. No partial load is retried. After RST falls, the block is in IDLE with OP_READY=1.
- Back-to-back: a new op may be accepted on the edge leaving FIN->IDLE plus one cycle. There is no accept in FIN.

Test Plan:
- Reset with OP_VALID=0:
  - All outputs 0 except OP_READY=1.
  - Assert RST mid-DST -> X_LOAD drops within the same cycle; state is IDLE afterwards.
- TAX (AA) with BUS=8'h80 in DST:
  - SRC: A_BE only.
  - DST: A_BE+X_LOAD, FLAG_WE=1, FLAG_N=1, FLAG_Z=0.
  - DONE pulse in the 3rd cycle after accept.
- INX (E8), model adjuster returning 8'h00 (X=FF):
  - SRC/DST: X_BE+INC_EN.
  - DST: X_LOAD, FLAG_Z=1, FLAG_N=0.
  - DEC_EN stays 0 throughout.
- TXS (9A) with BUS=8'h00: X_BE, then S_LOAD; FLAG_WE stays 0 for the whole op.
- Opcode 8'hEA (NOP, unsupported):
  - No _BE/_LOAD/INC/DEC ever.
  - DONE=1 and ILLEGAL=1 one cycle after accept.
- Back-to-back TAY then DEY with OP_VALID held high:
  - OP_READY low for 3 cycles between accepts.
  - Second op is accepted in IDLE only.
  - Scoreboard shows Y_LOAD twice.
  - No overlapping strobes; one-hot _BE/_LOAD checked every cycle.
